// File: rtl/package_settings.sv
// Global data-path settings shared across the signal chain.
// SIZE_ADC_DATA is the emulated ADC sample width.
package package_settings;
  localparam int SIZE_ADC_DATA = 14;
endpackage

// File: rtl/pulse_gen_parameters.sv
// Shared types and constants for the pulse_gen block.
// Optional feature macro: PULSE_GEN_NOISE_EN.
package pulse_gen_parameters;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2,
    WAIT  = 2'd3
  } pulse_gen_state_t;
endpackage

// File: rtl/pulse_gen_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) for dither noise.
// Only instantiated when PULSE_GEN_NOISE_EN is defined.
module pulse_gen_lfsr
  import pulse_gen_parameters::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] lsb
);

  logic [LFSR_W-1:0] lfsr;
  logic              fb;

  assign fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign lsb = lfsr[1:0];

  // shift right every cycle, feedback into the MSB
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {fb, lfsr[LFSR_W-1:1]};
  end

endmodule

// File: rtl/pulse_gen.sv
// Detector pulse emulator: linear rise, exponential decay, auto-repeat.
// Define PULSE_GEN_NOISE_EN to add LFSR dither noise to the output.
module pulse_gen
  import package_settings::*;
  import pulse_gen_parameters::*;
#(
  parameter int RISE_SHIFT  = 2,
  parameter int DECAY_SHIFT = 4,
  parameter int MAX_LEN     = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic        [SIZE_ADC_DATA-2:0] amplitude,
  input  logic        [15:0]              period,
  input  logic signed [SIZE_ADC_DATA-1:0] baseline,
  output logic signed [SIZE_ADC_DATA-1:0] output_data,
  output logic                            busy,
  output logic                            pulse_done
);

  localparam int EW       = SIZE_ADC_DATA + 1;
  localparam int SW       = SIZE_ADC_DATA + 3;
  localparam int RW       = RISE_SHIFT + 1;
  localparam int DW       = $clog2(MAX_LEN + 1);
  localparam int RISE_LEN = 1 << RISE_SHIFT;

  localparam logic signed [SW-1:0] SMAX =
    SW'((1 << (SIZE_ADC_DATA - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = ~SMAX;

  pulse_gen_state_t          state;
  logic [SIZE_ADC_DATA-2:0]  amp_q;
  logic [EW-1:0]             env;
  logic [RW-1:0]             rise_cnt;
  logic [DW-1:0]             dec_cnt;
  logic [DW-1:0]             dec_nxt;
  logic [15:0]               per_cnt;
  logic [15:0]               per_q;
  logic [16:0]               per_nxt;
  logic [EW-1:0]             rise_step;
  logic [EW-1:0]             decay_step;
  logic                      rise_last;
  logic                      dec_end;
  logic signed [SW-1:0]      noise;
  logic signed [SW-1:0]      sum;
  logic signed [SIZE_ADC_DATA-1:0] sat;

  assign busy       = (state != IDLE);
  assign rise_step  = EW'(amp_q >> RISE_SHIFT);
  assign decay_step = env >> DECAY_SHIFT;
  assign rise_last  = (rise_cnt == RW'(RISE_LEN - 1));
  assign dec_nxt    = dec_cnt + DW'(1);
  assign dec_end    = (decay_step == '0) ||
                      (dec_nxt == DW'(MAX_LEN));
  assign per_nxt    = {1'b0, per_cnt} + 17'd1;

`ifdef PULSE_GEN_NOISE_EN
  logic [1:0] nz_bits;

  pulse_gen_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lsb   (nz_bits)
  );

  assign noise = {{(SW-2){1'b0}}, nz_bits} - SW'(2);
`else
  assign noise = '0;
`endif

  assign sum = {{(SW-SIZE_ADC_DATA){baseline[SIZE_ADC_DATA-1]}},
                baseline}
             + {{(SW-EW){1'b0}}, env}
             + noise;

  // clamp the wide sum to the signed ADC range
  always_comb begin
    sat = sum[SIZE_ADC_DATA-1:0];
    unique case (1'b1)
      (sum > SMAX): sat = SMAX[SIZE_ADC_DATA-1:0];
      (sum < SMIN): sat = SMIN[SIZE_ADC_DATA-1:0];
      default:      sat = sum[SIZE_ADC_DATA-1:0];
    endcase
  end

  // envelope FSM: idle, linear rise, exponential decay, period wait
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      amp_q      <= '0;
      env        <= '0;
      rise_cnt   <= '0;
      dec_cnt    <= '0;
      per_cnt    <= '0;
      per_q      <= '0;
      pulse_done <= 1'b0;
    end else begin
      pulse_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            amp_q    <= amplitude;
            env      <= '0;
            rise_cnt <= '0;
            per_cnt  <= '0;
            state    <= RISE;
          end
        end
        RISE: begin
          per_cnt  <= per_nxt[15:0];
          rise_cnt <= rise_cnt + RW'(1);
          if (rise_last) begin
            env     <= EW'(amp_q);
            dec_cnt <= '0;
            state   <= DECAY;
          end else begin
            env <= env + rise_step;
          end
        end
        DECAY: begin
          per_cnt <= per_nxt[15:0];
          dec_cnt <= dec_nxt;
          if (dec_end) begin
            env        <= '0;
            pulse_done <= 1'b1;
            per_q      <= period;
            state      <= (period == 16'd0) ? IDLE : WAIT;
          end else begin
            env <= env - decay_step;
          end
        end
        WAIT: begin
          if (per_nxt >= {1'b0, per_q}) begin
            amp_q    <= amplitude;
            env      <= '0;
            rise_cnt <= '0;
            per_cnt  <= '0;
            state    <= RISE;
          end else begin
            per_cnt <= per_nxt[15:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // registered output sample, one cycle behind env
  always_ff @(posedge clk) begin
    if (reset) output_data <= '0;
    else       output_data <= sat;
  end

endmodule
